pwm_dac: RTL and testbench

- Output stage directly downstream of the waveform generator.
- Consumes the generator's 8-bit wave samples (post wave-select and amplitude mux) and converts each into a single-bit PWM stream for an external RC filter or DAC pin.
- A one-entry hold buffer with valid/ready handshake decouples the generator's sample rate from the PWM period.
- A new duty value is applied only on a PWM period boundary.

---
 rtl/pwm_dac_pkg.sv | 16 +
 rtl/pwm_dac_tick_gen.sv | 42 ++++
 rtl/pwm_dac.sv | 113 +++++++++++
 tb/tb_pwm_dac.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_dac_pkg.sv
// Shared waveform-generator definitions: DAC sample width, the last counter
// position of a PWM period, and the sample type carried from the generator
// output into the PWM stage.
package pwm_dac_pkg;

  localparam int DAC_WIDTH = 8;
  localparam int PWM_MAX   = 2**DAC_WIDTH - 2;

  typedef logic [DAC_WIDTH-1:0] sample_t;

  // Width of a modulo-N counter; never narrower than one bit.
  function automatic int pre_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/pwm_dac_tick_gen.sv
// Prescale divider: emits a one-cycle tick every PRESCALE clocks.
// Holding 'clear' parks the counter at zero so the next tick lands
// exactly PRESCALE cycles after clear is released.
module tick_gen
  import pwm_dac_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int              PRE_W    = pre_width(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt_reg;
  logic [PRE_W-1:0] pre_cnt_next;

  assign tick = (pre_cnt_reg == PRE_LAST);

  // Next prescale count: wrap on tick, park at zero while cleared.
  always_comb begin
    pre_cnt_next = pre_cnt_reg;
    if (clear || tick) begin
      pre_cnt_next = '0;
    end else begin
      pre_cnt_next = pre_cnt_reg + 1'b1;
    end
  end

  // Prescale counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_cnt_reg <= '0;
    end else begin
      pre_cnt_reg <= pre_cnt_next;
    end
  end

endmodule

// File: rtl/pwm_dac.sv
// PWM output stage. A one-entry hold buffer takes samples from the waveform
// generator; the held sample becomes the duty value at the next period
// boundary (or immediately while the stage is idle). Outputs are registered
// from next-state values so they describe the counter state of the same cycle.
module pwm_dac
  import pwm_dac_pkg::*;
#(
  parameter int WIDTH    = DAC_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             pwm_out,
  output logic             period_start,
  output logic [WIDTH-1:0] duty_level
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(2**WIDTH - 2);

  logic             run_reg;
  logic [WIDTH-1:0] cnt_reg,          cnt_next;
  logic [WIDTH-1:0] hold_reg,         hold_next;
  logic             hold_full_reg,    hold_full_next;
  logic [WIDTH-1:0] duty_reg,         duty_next;
  logic             pwm_reg,          pwm_next;
  logic             period_start_reg, period_start_next;

  logic tick;
  logic running;
  logic boundary;
  logic load;
  logic accept;

  // The counters only run once en has been high for a full cycle; the
  // first enabled edge restarts the period at position zero.
  assign running = en & run_reg;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (~running),
    .tick  (tick)
  );

  assign sample_ready = rst & ~hold_full_reg;
  assign accept       = sample_valid & sample_ready;
  assign boundary     = running & tick & (cnt_reg == CNT_MAX);
  // Duty may change at a period boundary, while idle, or at the restart edge.
  assign load         = ~running | boundary;

  assign pwm_out      = pwm_reg;
  assign period_start = period_start_reg;
  assign duty_level   = duty_reg;

  // Next-state logic for counter, hold buffer, duty and outputs.
  always_comb begin
    cnt_next          = cnt_reg;
    hold_next         = hold_reg;
    hold_full_next    = hold_full_reg;
    duty_next         = duty_reg;
    pwm_next          = 1'b0;
    period_start_next = 1'b0;

    if (!running) begin
      cnt_next = '0;
    end else if (tick) begin
      cnt_next = boundary ? '0 : cnt_reg + 1'b1;
    end

    if (load && hold_full_reg) begin
      duty_next      = hold_reg;
      hold_full_next = 1'b0;
    end

    // Accept only happens with an empty buffer, so it never races the load.
    if (accept) begin
      hold_next      = sample_in;
      hold_full_next = 1'b1;
    end

    // Full-scale duty exceeds the largest count, so it stays high across wrap.
    pwm_next          = en & (cnt_next < duty_next);
    period_start_next = en & (~run_reg | boundary);
  end

  // State registers with synchronous active-low reset; reset drops any held sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      run_reg          <= 1'b0;
      cnt_reg          <= '0;
      hold_reg         <= '0;
      hold_full_reg    <= 1'b0;
      duty_reg         <= '0;
      pwm_reg          <= 1'b0;
      period_start_reg <= 1'b0;
    end else begin
      run_reg          <= en;
      cnt_reg          <= cnt_next;
      hold_reg         <= hold_next;
      hold_full_reg    <= hold_full_next;
      duty_reg         <= duty_next;
      pwm_reg          <= pwm_next;
      period_start_reg <= period_start_next;
    end
  end

endmodule

// File: tb/tb_pwm_dac.sv
// Directed bench for pwm_dac: default instance (PRESCALE=1) plus a PRESCALE=4
// instance that stays in reset until its own scenario.
module tb_pwm_dac;
  import pwm_dac_pkg::*;

  logic    clk = 1'b0;
  logic    rst = 1'b0;
  logic    en = 1'b0;
  sample_t sample_in = '0;
  logic    sample_valid = 1'b0;
  logic    sample_ready;
  logic    pwm_out;
  logic    period_start;
  sample_t duty_level;

  logic    rst4 = 1'b0;
  logic    en4 = 1'b0;
  sample_t sample_in4 = '0;
  logic    sample_valid4 = 1'b0;
  logic    sample_ready4;
  logic    pwm_out4;
  logic    period_start4;
  sample_t duty_level4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_dac #(.WIDTH(8), .PRESCALE(1)) dut (
    .clk(clk), .rst(rst), .en(en), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .pwm_out(pwm_out), .period_start(period_start), .duty_level(duty_level)
  );

  pwm_dac #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst4), .en(en4), .sample_in(sample_in4),
    .sample_valid(sample_valid4), .sample_ready(sample_ready4),
    .pwm_out(pwm_out4), .period_start(period_start4), .duty_level(duty_level4)
  );

  // Advance one clock; outputs are then read 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until period_start is high (no step if already high), bounded.
  task automatic wait_ps(output bit ok);
    ok = period_start;
    for (int i = 0; i < 2000 && !ok; i++) begin
      step();
      ok = period_start;
    end
  endtask

  // From a period_start cycle, run one full period counting high cycles;
  // optionally offer a sample on the first cycle. Ends on the next period_start.
  task automatic measure_period(input bit push, input sample_t val,
                                output int highs, output int len);
    highs = 0;
    len   = 0;
    if (push) begin
      sample_in    = val;
      sample_valid = 1'b1;
    end
    do begin
      if (pwm_out) highs++;
      len++;
      step();
      sample_valid = 1'b0;
    end while (!period_start && len < 2000);
  endtask

  task automatic test_reset();
    int ps_cnt;
    int hi_cnt;
    int last_ps;
    rst = 1'b0;
    en  = 1'b1;
    repeat (3) step();
    checks++;
    if (pwm_out !== 1'b0 || period_start !== 1'b0 || duty_level !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: got pwm=%b ps=%b duty=%0d expected 0 0 0",
               pwm_out, period_start, duty_level);
    end
    checks++;
    if (sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low: got %b expected 0", sample_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_release: got %b expected 1", sample_ready);
    end
    ps_cnt = 0;
    hi_cnt = 0;
    last_ps = -1;
    for (int i = 0; i < 510; i++) begin
      step();
      if (period_start) begin
        ps_cnt++;
        last_ps = i;
      end
      if (pwm_out) hi_cnt++;
    end
    checks++;
    if (hi_cnt != 0) begin
      errors++;
      $display("FAIL idle_pwm_low: got %0d high cycles expected 0", hi_cnt);
    end
    checks++;
    if (ps_cnt != 2 || last_ps != 255) begin
      errors++;
      $display("FAIL idle_period_start: got %0d pulses last at %0d expected 2 pulses last at 255",
               ps_cnt, last_ps);
    end
    checks++;
    if (duty_level !== 8'd0) begin
      errors++;
      $display("FAIL idle_duty: got %0d expected 0", duty_level);
    end
    $display("test_reset: pulses=%0d highs=%0d", ps_cnt, hi_cnt);
  endtask

  task automatic test_push_128();
    bit ok;
    int highs;
    int len;
    sample_in    = 8'd128;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    checks++;
    if (sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL push128_ready_drop: got %b expected 0", sample_ready);
    end
    step();
    wait_ps(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push128_timeout: got no period_start expected one");
    end
    checks++;
    if (duty_level !== 8'd128 || sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL push128_apply: got duty=%0d ready=%b expected 128 1",
               duty_level, sample_ready);
    end
    measure_period(1'b0, 8'd0, highs, len);
    checks++;
    if (highs != 128 || len != 255) begin
      errors++;
      $display("FAIL push128_period: got high=%0d len=%0d expected 128 255", highs, len);
    end
    $display("test_push_128: high=%0d len=%0d", highs, len);
  endtask

  task automatic test_extremes();
    int highs;
    int len;
    measure_period(1'b1, 8'd255, highs, len);
    checks++;
    if (duty_level !== 8'd255) begin
      errors++;
      $display("FAIL full_apply: got duty=%0d expected 255", duty_level);
    end
    measure_period(1'b1, 8'd0, highs, len);
    checks++;
    if (highs != 255 || len != 255) begin
      errors++;
      $display("FAIL full_period: got high=%0d len=%0d expected 255 255", highs, len);
    end
    $display("test_extremes: duty255 high=%0d len=%0d", highs, len);
    measure_period(1'b0, 8'd0, highs, len);
    checks++;
    if (highs != 0 || len != 255) begin
      errors++;
      $display("FAIL zero_period: got high=%0d len=%0d expected 0 255", highs, len);
    end
    $display("test_extremes: duty0 high=%0d len=%0d", highs, len);
  endtask

  task automatic test_hold_full();
    int highs;
    int len;
    int waited;
    sample_in    = 8'd64;
    sample_valid = 1'b1;
    step();
    sample_in = 8'd200;
    checks++;
    if (sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_ready_low: got %b expected 0", sample_ready);
    end
    waited = 0;
    while (!sample_ready && waited < 600) begin
      step();
      waited++;
    end
    checks++;
    if (period_start !== 1'b1 || duty_level !== 8'd64) begin
      errors++;
      $display("FAIL hold_first: got ps=%b duty=%0d after %0d cycles expected 1 64",
               period_start, duty_level, waited);
    end
    highs = 0;
    len   = 0;
    do begin
      if (pwm_out) highs++;
      len++;
      step();
      sample_valid = 1'b0;
    end while (!period_start && len < 2000);
    checks++;
    if (highs != 64 || len != 255) begin
      errors++;
      $display("FAIL hold_period_n: got high=%0d len=%0d expected 64 255", highs, len);
    end
    checks++;
    if (duty_level !== 8'd200) begin
      errors++;
      $display("FAIL hold_second: got duty=%0d expected 200", duty_level);
    end
    measure_period(1'b0, 8'd0, highs, len);
    checks++;
    if (highs != 200 || len != 255) begin
      errors++;
      $display("FAIL hold_period_n1: got high=%0d len=%0d expected 200 255", highs, len);
    end
    $display("test_hold_full: period N+1 high=%0d", highs);
  endtask

  task automatic test_enable();
    int highs;
    int len;
    en = 1'b0;
    step();
    checks++;
    if (pwm_out !== 1'b0 || period_start !== 1'b0) begin
      errors++;
      $display("FAIL en_low_outputs: got pwm=%b ps=%b expected 0 0", pwm_out, period_start);
    end
    sample_in    = 8'd50;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    checks++;
    if (duty_level !== 8'd50 || sample_ready !== 1'b1 || pwm_out !== 1'b0) begin
      errors++;
      $display("FAIL en_low_transfer: got duty=%0d ready=%b pwm=%b expected 50 1 0",
               duty_level, sample_ready, pwm_out);
    end
    en = 1'b1;
    step();
    checks++;
    if (period_start !== 1'b1 || pwm_out !== 1'b1) begin
      errors++;
      $display("FAIL en_rise: got ps=%b pwm=%b expected 1 1", period_start, pwm_out);
    end
    measure_period(1'b0, 8'd0, highs, len);
    checks++;
    if (highs != 50 || len != 255) begin
      errors++;
      $display("FAIL en_period: got high=%0d len=%0d expected 50 255", highs, len);
    end
    $display("test_enable: high=%0d len=%0d", highs, len);
  endtask

  task automatic test_prescale();
    int highs;
    int len;
    int waited;
    checks++;
    if (sample_ready4 !== 1'b0 || pwm_out4 !== 1'b0) begin
      errors++;
      $display("FAIL ps4_reset: got ready=%b pwm=%b expected 0 0", sample_ready4, pwm_out4);
    end
    rst4 = 1'b1;
    en4  = 1'b1;
    step();
    checks++;
    if (period_start4 !== 1'b1) begin
      errors++;
      $display("FAIL ps4_first_start: got %b expected 1", period_start4);
    end
    sample_in4    = 8'd10;
    sample_valid4 = 1'b1;
    step();
    sample_valid4 = 1'b0;
    waited = 0;
    while (!period_start4 && waited < 2000) begin
      step();
      waited++;
    end
    checks++;
    if (duty_level4 !== 8'd10) begin
      errors++;
      $display("FAIL ps4_apply: got duty=%0d expected 10", duty_level4);
    end
    highs = 0;
    len   = 0;
    do begin
      if (pwm_out4) highs++;
      len++;
      step();
    end while (!period_start4 && len < 3000);
    checks++;
    if (highs != 40 || len != 1020) begin
      errors++;
      $display("FAIL ps4_period: got high=%0d len=%0d expected 40 1020", highs, len);
    end
    $display("test_prescale: high=%0d len=%0d", highs, len);
    sample_in4    = 8'd99;
    sample_valid4 = 1'b1;
    step();
    sample_valid4 = 1'b0;
    repeat (18) step();
    checks++;
    if (pwm_out4 !== 1'b1 || sample_ready4 !== 1'b0) begin
      errors++;
      $display("FAIL ps4_mid: got pwm=%b ready=%b expected 1 0", pwm_out4, sample_ready4);
    end
    rst4 = 1'b0;
    step();
    checks++;
    if (pwm_out4 !== 1'b0 || duty_level4 !== 8'd0 || period_start4 !== 1'b0) begin
      errors++;
      $display("FAIL ps4_abort: got pwm=%b duty=%0d ps=%b expected 0 0 0",
               pwm_out4, duty_level4, period_start4);
    end
    rst4 = 1'b1;
    en4  = 1'b0;
    #1;
    checks++;
    if (sample_ready4 !== 1'b1) begin
      errors++;
      $display("FAIL ps4_hold_cleared: got ready=%b expected 1", sample_ready4);
    end
    step();
    checks++;
    if (duty_level4 !== 8'd0) begin
      errors++;
      $display("FAIL ps4_no_retain: got duty=%0d expected 0", duty_level4);
    end
    $display("test_prescale: reset abort duty=%0d", duty_level4);
  endtask

  initial begin
    test_reset();
    test_push_128();
    test_extremes();
    test_hold_full();
    test_enable();
    test_prescale();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
